alu_share_arb: RTL
==================

Name: alu_share_arb

Overview:
- Time-shares one combinational ALU (4-bit ALUOP, 32-bit A/B, 5-bit shift amount, 32-bit result plus equal flag) between two requesters.
  - Requester 0: execute-stage instruction issue.
  - Requester 1: auxiliary sequencer, e.g. address/compare helper.
- Arbitrates round-robin, registers operands, drives the shared ALU, captures the result and returns it with a valid/ready handshake to the winning requester.
- Sits between the requesters and the ALU instance. The ALU itself stays outside this block.

Parameters:
- TAG_W, 4, width of the opaque request tag echoed back with the result.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- req_valid  in  2  per-requester request valid; bit i = requester i.
- req_ready  out  2  per-requester accept; a transfer occurs when req_valid[i] & req_ready[i].
- req_op0, req_op1  in  4 each  ALU opcode from requester 0 / 1.
- req_a0, req_a1  in  32 each  operand A.
- req_b0, req_b1  in  32 each  operand B.
- req_s0, req_s1  in  5 each  shift amount.
- req_tag0, req_tag1  in  TAG_W each  request tag.
- alu_op  out  4  to ALU ALUOP.
- alu_a  out  32  to ALU operand A.
- alu_b  out  32  to ALU operand B.
- alu_s  out  5  to ALU shift amount.
- alu_c  in  32  ALU result.
- alu_eq  in  1  ALU equal flag.
- rsp_valid  out  2  result valid for requester i; at most one bit set.
- rsp_ready  in  2  requester i accepts result.
- rsp_data  out  32  captured result.
- rsp_eq  out  1  captured equal flag.
- rsp_err  out  1  1 if the opcode was outside 0..7 (ALU returns 0).
- rsp_tag  out  TAG_W  echoed tag.
- busy  out  1  FSM not in IDLE.

Behaviour:
- FSM states: IDLE, EXEC, HOLD.
- Registers: op/a/b/s/tag operand registers, owner bit, last-grant pointer `lg`, result registers.

Reset (reset=0, asynchronous):
- State -> IDLE.
- All operand/result registers -> 0; owner -> 0.
- `lg` -> 1, so requester 0 wins the first tie.
- Outputs: req_ready=00, rsp_valid=00, alu_* = 0, rsp_data/rsp_eq/rsp_err/rsp_tag = 0, busy=0.
- Reset asserted mid-operation discards the in-flight request and any result silently.
- Deassertion is seen at the next clk edge; no request is accepted in the cycle reset is low.

IDLE:
- req_ready is combinational: one-hot grant to the valid requester.
  - Both valid: grant goes to the requester not equal to `lg`.
  - None valid: req_ready=00.
- On a transfer: capture op/a/b/s/tag of the winner; owner <= winner; `lg` <= winner; go to EXEC.

EXEC (exactly 1 cycle):
- alu_op/a/b/s driven from the operand registers; req_ready=00.
- At the clock edge: rsp_data<=alu_c, rsp_eq<=alu_eq, rsp_err<=(op>7); go to HOLD.

HOLD:
- rsp_valid[owner]=1; rsp_data/eq/err/tag stable.
- When rsp_ready[owner]=1: go to IDLE at that edge.
- No new request is accepted in HOLD (no bypass).
- rsp_ready of the non-owner is ignored.

Timing:
- Latency from accept edge (cycle N) to rsp_valid high: rsp_valid rises after the edge ending cycle N+1.
- Minimum spacing between accepts: 3 cycles.

Operand/output rules:
- alu_* outputs hold the registered operands in EXEC and HOLD; they are 0 only after reset.
- Requester inputs are sampled only at the accept edge; later changes have no effect.

Fairness:
- A requester held valid is granted within 2 grants.
- A requester deasserting valid before grant is allowed; no grant is recorded for it.

Test Plan:
- Single request r0: op=0 (add), a=5, b=7, tag=3 -> req_ready0 high in the same cycle; rsp_valid=01 two edges later; rsp_data=12, rsp_eq=0, rsp_tag=3.
- Both valid continuously, r0 op=1 (sub) a=b=9, r1 op=4 (sll) b=1, s=31 -> grants alternate r0, r1, r0. r0 result 0 with eq=1; r1 result 0x80000000.
- Backpressure: r1 op=3 (lui) b=0x1234, rsp_ready=0 for 5 cycles -> rsp_valid=10 held with rsp_data=0x12340000 stable; req_ready=00 throughout; release -> IDLE next edge.
- Illegal op: op=9 -> rsp_data=0, rsp_err=1.
- Reset mid-EXEC: assert reset (reset=0) during EXEC -> busy/rsp_valid/req_ready drop immediately; after release the next request from r0 gets the first grant and returns the correct result.
- Input change after accept: modify req_a0 the cycle after accept -> result reflects the originally sampled operand.

Source files
------------

// File: rtl/alu_share_arb.sv
// alu_share_arb: round-robin time-sharing of one external ALU
// between the execute stage (r0) and an auxiliary sequencer (r1).
module alu_share_arb #(
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [3:0]       req_op0,
    input  logic [3:0]       req_op1,
    input  logic [31:0]      req_a0,
    input  logic [31:0]      req_a1,
    input  logic [31:0]      req_b0,
    input  logic [31:0]      req_b1,
    input  logic [4:0]       req_s0,
    input  logic [4:0]       req_s1,
    input  logic [TAG_W-1:0] req_tag0,
    input  logic [TAG_W-1:0] req_tag1,
    output logic [3:0]       alu_op,
    output logic [31:0]      alu_a,
    output logic [31:0]      alu_b,
    output logic [4:0]       alu_s,
    input  logic [31:0]      alu_c,
    input  logic             alu_eq,
    output logic [1:0]       rsp_valid,
    input  logic [1:0]       rsp_ready,
    output logic [31:0]      rsp_data,
    output logic             rsp_eq,
    output logic             rsp_err,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [3:0]       op_q, op_d;
    logic [31:0]      a_q, a_d;
    logic [31:0]      b_q, b_d;
    logic [4:0]       s_q, s_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic             owner_q, owner_d;
    logic             lg_q, lg_d;
    logic [31:0]      data_q, data_d;
    logic             eq_q, eq_d;
    logic             err_q, err_d;

    logic [1:0]       gnt;
    logic             win;
    logic             xfer;

    // Round-robin pick: on a tie the requester that did not win last goes.
    always_comb begin
        gnt = 2'b00;
        if (req_valid == 2'b11) begin
            gnt = lg_q ? 2'b01 : 2'b10;
        end else begin
            gnt = req_valid;
        end
    end

    // Accept only from IDLE and never while reset is held low.
    assign req_ready = ((state_q == IDLE) && reset) ? gnt : 2'b00;
    assign xfer      = |(req_valid & req_ready);
    assign win       = gnt[1];

    // Next-state and register-load logic for the IDLE/EXEC/HOLD sequence.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        tag_d   = tag_q;
        owner_d = owner_q;
        lg_d    = lg_q;
        data_d  = data_q;
        eq_d    = eq_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (xfer) begin
                    op_d    = win ? req_op1  : req_op0;
                    a_d     = win ? req_a1   : req_a0;
                    b_d     = win ? req_b1   : req_b0;
                    s_d     = win ? req_s1   : req_s0;
                    tag_d   = win ? req_tag1 : req_tag0;
                    owner_d = win;
                    lg_d    = win;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                data_d  = alu_c;
                eq_d    = alu_eq;
                err_d   = (op_q > 4'd7);
                state_d = HOLD;
            end
            HOLD: begin
                if (rsp_ready[owner_q]) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, operand and result registers; lg resets to 1 so r0 wins first.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            tag_q   <= '0;
            owner_q <= 1'b0;
            lg_q    <= 1'b1;
            data_q  <= '0;
            eq_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            tag_q   <= tag_d;
            owner_q <= owner_d;
            lg_q    <= lg_d;
            data_q  <= data_d;
            eq_q    <= eq_d;
            err_q   <= err_d;
        end
    end

    assign alu_op    = op_q;
    assign alu_a     = a_q;
    assign alu_b     = b_q;
    assign alu_s     = s_q;

    assign rsp_valid = (state_q == HOLD) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
    assign rsp_data  = data_q;
    assign rsp_eq    = eq_q;
    assign rsp_err   = err_q;
    assign rsp_tag   = tag_q;
    assign busy      = (state_q != IDLE);

endmodule
